ysyx_23060075_div_seq: RTL and testbench
========================================

# ysyx_23060075_div_seq

Iterative radix-2 restoring divider, the inverse companion of the adder/subtractor ALU. Computes quotient and remainder of two `data_len`-bit operands, signed or unsigned, with RISC-V M-extension semantics for the corner cases (divide-by-zero, signed overflow). Sits beside the EXU ALU and serves DIV/DIVU/REM/REMU through a valid/ready handshake on each side. Each iteration does one trial subtract on a `ysyx_23060075_adder_alu` instance with `is_sub=1`.

## Interface
- `data_len`, default 32, operand/result width (≥2)
- `clk` input 1 rising-edge clock
- `rst` input 1 synchronous active-high reset
- `in_valid` input 1 request present
- `in_ready` output 1 divider idle, can accept
- `dividend` input data_len
- `divisor` input data_len
- `is_signed` input 1 two's-complement operation when 1
- `out_valid` output 1 result available
- `out_ready` input 1 consumer takes result
- `quotient` output data_len
- `remainder` output data_len

## Operation
- FSM: IDLE, BUSY, DONE. `in_ready` = (state==IDLE). `out_valid` = (state==DONE).
- IDLE: on `in_valid && in_ready`, latch operand magnitudes. Take |x| only if `is_signed` and the MSB is 1. Also latch the result sign flags, clear the partial remainder, set the step counter to 0, go BUSY.
- BUSY, one step per cycle:
  - Shift {rem, quo} left 1, with the dividend bit entering at the bottom.
  - Trial subtract rem − divisor on a (data_len+1)-bit adder_alu.
  - No borrow (`carry`==0): keep the difference and set quo[0]=1. Otherwise restore and set quo[0]=0.
  - After step data_len−1, go DONE.
- Entering DONE, apply sign correction. Quotient is negated if signed and operand signs differ. Remainder takes the sign of the dividend.
- Corner cases, which override the iterative result:
  - divisor==0: quotient = all ones, remainder = dividend. This holds for both signed and unsigned.
  - Signed, dividend = most-negative, divisor = all ones: quotient = dividend, remainder = 0.
- DONE: `quotient`/`remainder` stay stable while `out_valid && !out_ready`. On `out_ready`, go IDLE.
- No new request is accepted in BUSY or DONE. `in_valid` is ignored there.
- Unsigned arithmetic is modulo 2^data_len. Negation is two's complement at data_len bits.

## Timing
- Reset (any state, including mid-BUSY or DONE): after the first clock edge with `rst`=1:
  - state is IDLE, `in_ready`=1, `out_valid`=0.
  - `quotient`=0, `remainder`=0, counter=0.
  - Any in-flight operation is discarded.
- Request handshake in cycle c: `in_ready`=0 from cycle c+1. `out_valid`=1 in cycle c+1+data_len (normal path).
- Output handshake in cycle d: `out_valid`=0 and `in_ready`=1 in cycle d+1. The minimum issue interval is data_len+2 cycles.
- Combinational paths: `in_ready` and `out_valid` depend on state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `YSYX_23060075_DIV_EARLY_OUT_EN`:
  - Defined: divide-by-zero and signed overflow are detected at acceptance and go IDLE→DONE directly. `out_valid` is 1 in cycle c+1.
  - Undefined: these cases run the full data_len BUSY steps and the override is applied entering DONE. Latency is c+1+data_len.
  - Result values are identical either way.

## Test plan
- data_len=8, unsigned 100/7 → quotient 14 (0x0E), remainder 2. `out_valid` is 1 exactly 9 cycles after the handshake.
- Signed 0xF9/0x02 (−7/2) → quotient 0xFD (−3), remainder 0xFF (−1). Unsigned 0xF9/0x02 → quotient 0x7C, remainder 0x01.
- Signed 0x85/0x00 → quotient 0xFF, remainder 0x85. Signed 0x80/0xFF → quotient 0x80, remainder 0x00. Latency is 1 cycle with the macro and 9 cycles without.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE and toggle `in_valid` with new operands. Outputs stay constant and no second request is taken. `out_ready`=1 → IDLE the next cycle.
- Pulse `rst` for 1 cycle at BUSY step 4, then issue 0x64/0x0A unsigned. The first op produces no result. The second gives quotient 0x0A, remainder 0x00 with normal latency.
- Back-to-back: 200 random signed and unsigned ops with random `in_valid`/`out_ready` stalls, compared against a reference model with RISC-V semantics.

Source files
------------

// File: rtl/ysyx_23060075_div_seq.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU) with valid/ready on both sides.
// Optional: define YSYX_23060075_DIV_EARLY_OUT_EN to resolve divide-by-zero and signed overflow at acceptance.

module ysyx_23060075_adder_alu #(
  parameter int unsigned data_len = 32
) (
  input  logic [data_len-1:0] a,
  input  logic [data_len-1:0] b,
  input  logic                is_sub,
  output logic [data_len-1:0] result,
  output logic                carry
);
  logic [data_len:0] sum;
  logic [data_len-1:0] b_eff;

  always_comb begin
    b_eff = is_sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{data_len{1'b0}}, is_sub};
  end

  assign result = sum[data_len-1:0];
  // For subtraction carry reports a borrow (a < b, unsigned)
  assign carry  = sum[data_len] ^ is_sub;
endmodule

module ysyx_23060075_div_seq #(
  parameter int unsigned data_len = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [data_len-1:0] dividend,
  input  logic [data_len-1:0] divisor,
  input  logic                is_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [data_len-1:0] quotient,
  output logic [data_len-1:0] remainder
);
  localparam int unsigned W  = data_len;
  localparam int unsigned CW = $clog2(data_len);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [W-1:0]    dvd_raw_q, dvd_raw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    quotient_q, quotient_d;
  logic [W-1:0]    remainder_q, remainder_d;

  logic [W:0]      trial_a, trial_b, trial_diff;
  logic            trial_borrow;
  logic            diff_msb_unused;
  logic [W-1:0]    step_rem, step_quo, fin_q, fin_r;
  logic            in_dvd_neg, in_dvs_neg, in_div0, in_ovf;
  logic [W-1:0]    mag_dvd, mag_dvs;

  // Partial remainder is W+1 bits once the next dividend bit is shifted in
  assign trial_a = {rem_q, quo_q[W-1]};
  assign trial_b = {1'b0, dvs_q};

  ysyx_23060075_adder_alu #(.data_len(W + 1)) u_trial_sub (
    .a      (trial_a),
    .b      (trial_b),
    .is_sub (1'b1),
    .result (trial_diff),
    .carry  (trial_borrow)
  );

  // A successful trial always leaves a value below the divisor, so the top bit is zero
  assign diff_msb_unused = trial_diff[W];

  always_comb begin
    step_rem   = trial_borrow ? trial_a[W-1:0] : trial_diff[W-1:0];
    step_quo   = {quo_q[W-2:0], ~trial_borrow};
    fin_q      = qneg_q ? -step_quo : step_quo;
    fin_r      = rneg_q ? -step_rem : step_rem;
    if (div0_q) begin
      fin_q = '1;
      fin_r = dvd_raw_q;
    end else if (ovf_q) begin
      fin_q = dvd_raw_q;
      fin_r = '0;
    end

    in_dvd_neg = is_signed & dividend[W-1];
    in_dvs_neg = is_signed & divisor[W-1];
    mag_dvd    = in_dvd_neg ? -dividend : dividend;
    mag_dvs    = in_dvs_neg ? -divisor : divisor;
    in_div0    = (divisor == '0);
    in_ovf     = is_signed & (dividend == {1'b1, {(W-1){1'b0}}}) & (divisor == '1);
  end

  always_comb begin
    state_d     = state_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    dvd_raw_d   = dvd_raw_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d   = S_BUSY;
          quo_d     = mag_dvd;
          rem_d     = '0;
          dvs_d     = mag_dvs;
          dvd_raw_d = dividend;
          cnt_d     = '0;
          qneg_d    = in_dvd_neg ^ in_dvs_neg;
          rneg_d    = in_dvd_neg;
          div0_d    = in_div0;
          ovf_d     = in_ovf;
`ifdef YSYX_23060075_DIV_EARLY_OUT_EN
          if (in_div0 || in_ovf) begin
            state_d     = S_DONE;
            quotient_d  = in_div0 ? '1 : dividend;
            remainder_d = in_div0 ? dividend : '0;
          end
`else
`endif
        end
      end
      S_BUSY: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d     = S_DONE;
          quotient_d  = fin_q;
          remainder_d = fin_r;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      dvd_raw_q   <= dvd_raw_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
endmodule

// File: tb/tb_ysyx_23060075_div_seq.sv
// Directed-vector and randomized bench for ysyx_23060075_div_seq at data_len=8.
module tb_ysyx_23060075_div_seq;
  localparam int unsigned W = 8;
`ifdef YSYX_23060075_DIV_EARLY_OUT_EN
  localparam int CORNER_LAT = 1;
`else
  localparam int CORNER_LAT = 9;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, is_signed, out_valid, out_ready;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  int           total = 0;
  int           bad = 0;

  ysyx_23060075_div_seq #(.data_len(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output logic [7:0] q, output logic [7:0] r);
    int sa, sb;
    if (b == 8'h00) begin
      q = 8'hFF;
      r = a;
    end else if (s && a == 8'h80 && b == 8'hFF) begin
      q = 8'h80;
      r = 8'h00;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Handshake, then count cycles from the accepting edge until out_valid
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
    int n;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("issue_ready_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, gap, stall;
    logic       seen;
    logic [7:0] a, b, eq, er, hq, hr;
    logic       s;

    vecs[0]  = '{8'd100, 8'd7,  1'b0, 8'h0E, 8'h02, 9};
    vecs[1]  = '{8'hF9,  8'h02, 1'b1, 8'hFD, 8'hFF, 9};
    vecs[2]  = '{8'hF9,  8'h02, 1'b0, 8'h7C, 8'h01, 9};
    vecs[3]  = '{8'h85,  8'h00, 1'b1, 8'hFF, 8'h85, CORNER_LAT};
    vecs[4]  = '{8'h80,  8'hFF, 1'b1, 8'h80, 8'h00, CORNER_LAT};
    vecs[5]  = '{8'h80,  8'hFF, 1'b0, 8'h00, 8'h80, 9};
    vecs[6]  = '{8'hFF,  8'h00, 1'b0, 8'hFF, 8'hFF, CORNER_LAT};
    vecs[7]  = '{8'hFF,  8'hFF, 1'b0, 8'h01, 8'h00, 9};
    vecs[8]  = '{8'h07,  8'hF9, 1'b1, 8'hFF, 8'h00, 9};
    vecs[9]  = '{8'h7F,  8'h80, 1'b1, 8'h00, 8'h7F, 9};
    vecs[10] = '{8'h81,  8'h03, 1'b1, 8'hD6, 8'hFF, 9};
    vecs[11] = '{8'h00,  8'h05, 1'b0, 8'h00, 8'h00, 9};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      drain();
      check($sformatf("vec%0d_idle_out_valid", i), out_valid, 0);
      check($sformatf("vec%0d_idle_in_ready", i), in_ready, 1);
    end

    // Backpressure in DONE with a new request dangling
    issue(8'd100, 8'd7, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      dividend = 8'($urandom);
      divisor  = 8'($urandom | 1);
      tick();
      check($sformatf("bp%0d_out_valid", i), out_valid, 1);
      check($sformatf("bp%0d_in_ready", i), in_ready, 0);
      check($sformatf("bp%0d_quotient", i), quotient, 8'h0E);
      check($sformatf("bp%0d_remainder", i), remainder, 8'h02);
    end
    in_valid = 1'b0;
    drain();
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (!in_ready || out_valid) seen = 1'b1;
    end
    check("bp_no_second_request", seen, 0);

    // Reset at BUSY step 4
    dividend = 8'h55; divisor = 8'h03; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_stale_result", seen, 0);
    issue(8'h64, 8'h0A, 1'b0, lat);
    check("midrst_next_latency", lat, 9);
    check("midrst_next_quotient", quotient, 8'h0A);
    check("midrst_next_remainder", remainder, 8'h00);
    drain();

    // Random back-to-back traffic with stalls on both sides
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      case ($urandom_range(0, 9))
        0: b = 8'h00;
        1: begin a = 8'h80; b = 8'hFF; s = 1'b1; end
        default: ;
      endcase
      model(a, b, s, eq, er);
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      issue(a, b, s, lat);
      if (!out_valid) check($sformatf("rand%0d_timeout", i), out_valid, 1);
      check($sformatf("rand%0d_latency", i), lat,
            ((b == 8'h00) || (s && a == 8'h80 && b == 8'hFF)) ? CORNER_LAT : 9);
      hq = quotient;
      hr = remainder;
      stall = $urandom_range(0, 3);
      repeat (stall) tick();
      check($sformatf("rand%0d_quotient", i), quotient, eq);
      check($sformatf("rand%0d_remainder", i), remainder, er);
      check($sformatf("rand%0d_hold", i), {hq, hr}, {quotient, remainder});
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
